// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding, ALU ops,
// opcodes and datapath mux selects.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_BTAKEN   = 4'd10,
    S_JLINK    = 4'd11,
    S_JJUMP    = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;

  // ALU A operand: PC or rs1; B operand: rs2, constant 4, immediate, link offset.
  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS1  = 2'b01;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_LINK = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// funct3/funct7 to ALU operation mapping, purely combinational (0 cycles).
// No flow control; legal_o flags the unsupported funct3=011 encoding.
module alu_decoder
  import control_fsm_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       rtype_i,
  output logic [3:0] alu_op_o,
  output logic       legal_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    legal_o  = 1'b1;
    case (funct3_i)
      // Only R-type uses bit 30 to pick SUB; addi treats it as immediate data.
      3'b000: alu_op_o = (rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001: alu_op_o = ALU_SLL;
      3'b010: alu_op_o = ALU_SLT;
      3'b011: legal_o  = 1'b0;
      3'b100: alu_op_o = ALU_XOR;
      3'b101: alu_op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110: alu_op_o = ALU_OR;
      3'b111: alu_op_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RISC-V style control FSM with Moore outputs; 3-5 cycles per instruction.
// No backpressure; ILLEGAL is terminal until reset, and reset forces write enables low.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        instruction_or_data,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [3:0]  state_dbg
);

  state_t      state_q, state_d;
  logic [31:0] retired_q;
  logic        illegal_q;

  logic        pc_write_c, ir_write_c, reg_write_c, mem_write_c;
  logic [3:0]  dec_alu_op;
  logic        dec_legal;
  logic        retire;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .funct3_i   (funct3),
    .funct7b5_i (instr[30]),
    .rtype_i    (opcode == OP_RTYPE),
    .alu_op_o   (dec_alu_op),
    .legal_o    (dec_legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    pc_write_c          = 1'b0;
    ir_write_c          = 1'b0;
    reg_write_c         = 1'b0;
    mem_write_c         = 1'b0;
    instruction_or_data = 1'b0;
    result_src          = RES_ALUOUT;
    alu_src_a           = SRCA_PC;
    alu_src_b           = SRCB_RS2;
    alu_control         = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = dec_legal ? S_EXECR : S_ILLEGAL;
          OP_ITYPE:          state_d = dec_legal ? S_EXECI : S_ILLEGAL;
          OP_BRANCH:         state_d = (funct3 == F3_BEQ) ? S_BEQ : S_ILLEGAL;
          OP_JAL:            state_d = S_JLINK;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        instruction_or_data = 1'b1;
        state_d             = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_RS1;
        alu_control = dec_alu_op;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu_op;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = SRCA_RS1;
        alu_control = ALU_SUB;
        state_d     = zero ? S_BTAKEN : S_FETCH;
      end
      S_BTAKEN, S_JJUMP: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        pc_write_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JLINK: begin
        alu_src_b   = SRCB_LINK;
        result_src  = RES_ALURES;
        reg_write_c = 1'b1;
        state_d     = S_JJUMP;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  // Gating with reset keeps the FETCH enables from firing while held in reset.
  assign pc_write  = pc_write_c  & reset;
  assign ir_write  = ir_write_c  & reset;
  assign reg_write = reg_write_c & reset;
  assign mem_write = mem_write_c & reset;

  assign retire = (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_JJUMP, S_BTAKEN}) ||
                  (state_q == S_BEQ && !zero);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (retire) retired_q <= retired_q + 32'd1;
      if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  assign retired   = retired_q;
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle state/enable/select/ALU vectors
// checked against hand-written expectations.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        pc_write, ir_write, reg_write, mem_write, instruction_or_data;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [3:0]  alu_control;
  logic        illegal;
  logic [31:0] retired;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  control_fsm dut (
    .clk                 (clk),
    .reset               (reset),
    .instr               (instr),
    .zero                (zero),
    .pc_write            (pc_write),
    .ir_write            (ir_write),
    .reg_write           (reg_write),
    .mem_write           (mem_write),
    .instruction_or_data (instruction_or_data),
    .result_src          (result_src),
    .alu_src_a           (alu_src_a),
    .alu_src_b           (alu_src_b),
    .alu_control         (alu_control),
    .illegal             (illegal),
    .retired             (retired),
    .state_dbg           (state_dbg)
  );

  always #5 clk = ~clk;

  // Observed vector: {state[3:0], {pc,ir,reg,mem,iod}, {result_src,src_a,src_b}, alu}
  wire [4:0]  en_obs  = {pc_write, ir_write, reg_write, mem_write, instruction_or_data};
  wire [5:0]  sel_obs = {result_src, alu_src_a, alu_src_b};
  wire [18:0] obs     = {state_dbg, en_obs, sel_obs, alu_control};

  localparam logic [18:0] V_FETCH    = {4'd0,  5'b11000, 6'b10_00_01, 4'b0000};
  localparam logic [18:0] V_DECODE   = {4'd1,  5'b00000, 6'b00_00_00, 4'b0000};
  localparam logic [18:0] V_MEMADR   = {4'd2,  5'b00000, 6'b00_01_10, 4'b0000};
  localparam logic [18:0] V_MEMREAD  = {4'd3,  5'b00001, 6'b00_00_00, 4'b0000};
  localparam logic [18:0] V_MEMWB    = {4'd4,  5'b00100, 6'b01_00_00, 4'b0000};
  localparam logic [18:0] V_MEMWRITE = {4'd5,  5'b00010, 6'b00_00_00, 4'b0000};
  localparam logic [18:0] V_EXECR    = {4'd6,  5'b00000, 6'b00_01_00, 4'b0000};
  localparam logic [18:0] V_EXECI    = {4'd7,  5'b00000, 6'b00_01_10, 4'b0000};
  localparam logic [18:0] V_ALUWB    = {4'd8,  5'b00100, 6'b00_00_00, 4'b0000};
  localparam logic [18:0] V_BEQ      = {4'd9,  5'b00000, 6'b00_01_00, 4'b0001};
  localparam logic [18:0] V_BTAKEN   = {4'd10, 5'b10000, 6'b10_00_10, 4'b0000};
  localparam logic [18:0] V_JLINK    = {4'd11, 5'b00100, 6'b10_00_11, 4'b0000};
  localparam logic [18:0] V_JJUMP    = {4'd12, 5'b10000, 6'b10_00_10, 4'b0000};
  localparam logic [18:0] V_ILLEGAL  = {4'd13, 5'b00000, 6'b00_00_00, 4'b0000};
  localparam logic [18:0] V_FETCH_RST = {4'd0, 5'b00000, 6'b10_00_01, 4'b0000};

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== V_FETCH_RST) begin
      errors++; $display("FAIL reset_outputs got %h want %h", obs, V_FETCH_RST);
    end
    checks++;
    if ({illegal, retired} !== 33'd0) begin
      errors++; $display("FAIL reset_flags got illegal=%b retired=%0d want 0/0", illegal, retired);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== V_FETCH) begin
      errors++; $display("FAIL release_fetch got %h want %h", obs, V_FETCH);
    end
  endtask

  task automatic test_add();
    logic [18:0] seq [4];
    seq = '{V_FETCH, V_DECODE, V_EXECR, V_ALUWB};
    instr = 32'h002081B3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL add_cycle%0d got %h want %h", i, obs, seq[i]);
      end
      tick();
    end
    exp_ret++;
    checks++;
    if (retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL add_retired got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_load();
    logic [18:0] seq [5];
    seq = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB};
    instr = 32'h00802283;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL lw_cycle%0d got %h want %h", i, obs, seq[i]);
      end
      tick();
    end
    exp_ret++;
    checks++;
    if (obs !== V_FETCH || retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL lw_done got %h/%0d want %h/%0d", obs, retired, V_FETCH, exp_ret);
    end
  endtask

  task automatic test_store();
    logic [18:0] seq [4];
    seq = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWRITE};
    instr = 32'h00502423;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL sw_cycle%0d got %h want %h", i, obs, seq[i]);
      end
      tick();
    end
    exp_ret++;
    checks++;
    if (obs !== V_FETCH || retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL sw_done got %h/%0d want %h/%0d", obs, retired, V_FETCH, exp_ret);
    end
  endtask

  task automatic test_beq();
    logic [18:0] taken [4];
    logic [18:0] fall [3];
    taken = '{V_FETCH, V_DECODE, V_BEQ, V_BTAKEN};
    fall  = '{V_FETCH, V_DECODE, V_BEQ};
    instr = 32'h00000463;
    zero  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== taken[i]) begin
        errors++; $display("FAIL beq_taken_cycle%0d got %h want %h", i, obs, taken[i]);
      end
      tick();
    end
    exp_ret++;
    checks++;
    if (obs !== V_FETCH || retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL beq_taken_done got %h/%0d want %h/%0d", obs, retired, V_FETCH, exp_ret);
    end
    zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== fall[i]) begin
        errors++; $display("FAIL beq_fall_cycle%0d got %h want %h", i, obs, fall[i]);
      end
      tick();
    end
    exp_ret++;
    checks++;
    if (obs !== V_FETCH || retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL beq_fall_done got %h/%0d want %h/%0d", obs, retired, V_FETCH, exp_ret);
    end
  endtask

  task automatic test_jal();
    logic [18:0] seq [4];
    seq = '{V_FETCH, V_DECODE, V_JLINK, V_JJUMP};
    instr = 32'h010000EF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL jal_cycle%0d got %h want %h", i, obs, seq[i]);
      end
      tick();
    end
    exp_ret++;
    checks++;
    if (obs !== V_FETCH || retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL jal_done got %h/%0d want %h/%0d", obs, retired, V_FETCH, exp_ret);
    end
  endtask

  // Back-to-back R/I-type ops, including sub->srai and addi with bit 30 set.
  task automatic test_back_to_back();
    logic [31:0] ins [9];
    logic        isr [9];
    logic [3:0]  op  [9];
    logic [18:0] seq [4];
    ins = '{32'h402081B3, 32'h40115093, 32'h0020E1B3, 32'h40000093, 32'h0020D1B3,
            32'h0020F1B3, 32'h0020A1B3, 32'h0040C093, 32'h00309093};
    isr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    op  = '{4'b0001, 4'b1000, 4'b0011, 4'b0000, 4'b0111, 4'b0010, 4'b0101, 4'b0100, 4'b0110};
    for (int k = 0; k < 9; k++) begin
      instr = ins[k];
      seq = '{V_FETCH, V_DECODE, (isr[k] ? V_EXECR : V_EXECI) | {15'd0, op[k]}, V_ALUWB};
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs !== seq[i]) begin
          errors++; $display("FAIL op%0d_cycle%0d instr=%h got %h want %h", k, i, ins[k], obs, seq[i]);
        end
        tick();
      end
      exp_ret++;
    end
    checks++;
    if (retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL b2b_retired got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [3];
    bad = '{32'h0000007F, 32'h0020B1B3, 32'h00001463};
    for (int k = 0; k < 3; k++) begin
      instr = bad[k];
      checks++;
      if (obs !== V_FETCH) begin
        errors++; $display("FAIL ill%0d_fetch got %h want %h", k, obs, V_FETCH);
      end
      tick();
      checks++;
      if (obs !== V_DECODE) begin
        errors++; $display("FAIL ill%0d_decode got %h want %h", k, obs, V_DECODE);
      end
      tick();
      instr = 32'h002081B3;
      for (int c = 0; c < 20; c++) begin
        checks++;
        if ({obs, illegal} !== {V_ILLEGAL, 1'b1}) begin
          errors++; $display("FAIL ill%0d_hold%0d got %h/%b want %h/1", k, c, obs, illegal, V_ILLEGAL);
        end
        tick();
      end
      checks++;
      if (retired !== 32'(exp_ret)) begin
        errors++; $display("FAIL ill%0d_retired got %0d want %0d", k, retired, exp_ret);
      end
      reset = 1'b0;
      #1;
      exp_ret = 0;
      checks++;
      if ({illegal, retired, obs} !== {1'b0, 32'd0, V_FETCH_RST}) begin
        errors++; $display("FAIL ill%0d_clear got ill=%b ret=%0d %h want 0/0/%h", k, illegal, retired, obs, V_FETCH_RST);
      end
      tick();
      reset = 1'b1;
      #1;
    end
  endtask

  task automatic test_reset_midload();
    logic [18:0] seq [4];
    seq = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD};
    instr = 32'h00802283;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL midld_cycle%0d got %h want %h", i, obs, seq[i]);
      end
      if (i < 3) tick();
    end
    #2;
    reset = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs !== V_FETCH_RST || retired !== 32'd0) begin
        errors++; $display("FAIL midld_rst%0d got %h/%0d want %h/0", c, obs, retired, V_FETCH_RST);
      end
      tick();
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== V_FETCH) begin
      errors++; $display("FAIL midld_release got %h want %h", obs, V_FETCH);
    end
    tick();
    checks++;
    if (obs !== V_DECODE || retired !== 32'd0) begin
      errors++; $display("FAIL midld_after got %h/%0d want %h/0", obs, retired, V_DECODE);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store();
    test_beq();
    test_jal();
    test_back_to_back();
    test_illegal();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low.
REQ-003 SHALL have port instr, input, 32 bits: current IR contents from the datapath.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag from the datapath.
REQ-005 SHALL have outputs pc_write, ir_write, reg_write, mem_write, instruction_or_data, 1 bit each: datapath enables and selects.
REQ-006 SHALL have outputs result_src, alu_src_a, alu_src_b, 2 bits each: datapath mux selects.
REQ-007 SHALL have output alu_control, 4 bits: ALU operation.
REQ-008 SHALL have output illegal, 1 bit: sticky flag for an unsupported instruction.
REQ-009 SHALL have output retired, 32 bits: count of completed instructions.
REQ-010 SHALL have output state_dbg, 4 bits: current state encoding.

Function
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, BTAKEN, JLINK, JJUMP and ILLEGAL.
REQ-012 Outputs SHALL be Moore, decoded from state only; alu_control in EXECR/EXECI SHALL also use instr.
REQ-013 Every output not listed for a state SHALL be 0; write enables SHALL never be X.
REQ-014 FETCH SHALL drive ir_write=1, instruction_or_data=0, alu_src_a=00, alu_src_b=01, ADD, result_src=10, pc_write=1; next state DECODE.
REQ-015 DECODE next state by instr[6:0]: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 with funct3=000 -> BEQ; 1101111 -> JLINK; any other value -> ILLEGAL.
REQ-016 MEMADR SHALL drive alu_src_a=01, alu_src_b=10, ADD; next state MEMREAD for loads, MEMWRITE for stores.
REQ-017 MEMREAD SHALL drive instruction_or_data=1, result_src=00; next state MEMWB.
REQ-018 MEMWB SHALL drive result_src=01, reg_write=1; next state FETCH.
REQ-019 MEMWRITE SHALL drive mem_write=1; next state FETCH.
REQ-020 EXECR SHALL drive alu_src_a=01, alu_src_b=00; EXECI SHALL drive alu_src_a=01, alu_src_b=10; both go next to ALUWB.
REQ-021 ALUWB SHALL drive result_src=00, reg_write=1; next state FETCH.
REQ-022 BEQ SHALL drive alu_src_a=01, alu_src_b=00, SUB; next state BTAKEN if zero=1, else FETCH.
REQ-023 BTAKEN SHALL drive alu_src_a=00, alu_src_b=10, ADD, result_src=10, pc_write=1; next state FETCH.
REQ-024 JLINK SHALL drive alu_src_a=00, alu_src_b=11, ADD, result_src=10, reg_write=1; next state JJUMP.
REQ-025 JJUMP SHALL be identical to BTAKEN.
REQ-026 ALU encodings SHALL be ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLL=0110, SRL=0111, SRA=1000.
REQ-027 R-type funct3 decode SHALL be: 000 -> ADD, or SUB when instr[30]=1; 001 -> SLL; 010 -> SLT; 100 -> XOR; 101 -> SRL, or SRA when instr[30]=1; 110 -> OR; 111 -> AND.
REQ-028 I-type decode SHALL match R-type, except funct3=000 SHALL always give ADD.
REQ-029 funct3=011 in R- or I-type SHALL send DECODE to ILLEGAL.
REQ-030 ILLEGAL SHALL drive all enables 0, set illegal=1, and hold until reset.
REQ-031 retired SHALL increment by 1 on each transition from MEMWB, MEMWRITE, ALUWB, JJUMP or BTAKEN to FETCH, and from BEQ to FETCH.
REQ-032 retired SHALL wrap from 0xFFFFFFFF to 0.
REQ-033 Latencies SHALL be: load 5 cycles; store, R-type, I-type and JAL 4 cycles; BEQ 3 cycles not taken, 4 taken.

Reset
REQ-034 While reset=0: state=FETCH, illegal=0, retired=0, and all write enables forced to 0.
REQ-035 Reset asserted mid-instruction SHALL abort it with no further write enable asserted.
REQ-036 Release of reset SHALL enter FETCH on the next rising clk.

Structure
REQ-037 A shared package SHALL hold the state enum, the ALU op constants, opcode constants, and mux select constants.
REQ-038 The funct3/funct7 to alu_control mapping SHALL be in a sub-module named alu_decoder.

Verification
REQ-039 add x3,x1,x2 (0x002081B3) -> FETCH, DECODE, EXECR (alu_control=0000), ALUWB (reg_write=1); retired +1.
REQ-040 lw x5,8(x0) (0x00802283) -> five states; instruction_or_data=1 in MEMREAD; result_src=01 in MEMWB.
REQ-041 beq x0,x0,+8 with zero=1 -> BEQ (SUB), BTAKEN (pc_write=1); with zero=0 -> FETCH after BEQ.
REQ-042 Opcode 0x7F -> ILLEGAL, illegal=1, no writes for 20 cycles, cleared by reset=0.
REQ-043 reset=0 asserted during MEMREAD of a load -> no reg_write; FETCH after release; retired=0.
REQ-044 sub then srai (0x40115093) -> alu_control 0001, then 1000.
